hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the multi-stage datapath. It keeps a per-stage scoreboard of in-flight instructions from EX through RW. From that scoreboard it produces the control the datapath needs to run back-to-back dependent instructions correctly:
- operand-forwarding selects for the instruction in OF,
- load-use stalls,
- branch flushes,
- stall/flush event counters.

Pipeline depth, register-address width and load-data availability stage are parameters, so the same block serves the 5-stage core and deeper variants.

## Interface
- DEPTH, 3: tracked stages after OF (stage 1 = EX, stage DEPTH = RW); legal 2..8
- REG_AW, 4: register address width
- LD_STAGE, 2: first stage (1..DEPTH) whose output holds load data (2 = MA)
- CNT_W, 16: width of event counters
- FS_W, $clog2(DEPTH+1): width of forwarding selects

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- of_valid  in  1  OF holds a real instruction
- of_rs1, of_rs2  in  REG_AW  source register addresses
- of_use_rs1, of_use_rs2  in  1  source actually read
- of_rd  in  REG_AW  destination (decoder supplies ra for call)
- of_wb, of_ld  in  1  OF instruction writes back / is a load
- isBranchtaken  in  1  EX resolved a taken branch, call or ret
- stall  out  1  hold IF and OF, inject bubble into EX
- flush  out  1  kill IF and OF contents
- fwd_sel1, fwd_sel2  out  FS_W  0 = register file, k = result of stage k
- stage_valid  out  DEPTH  valid bit of each tracked stage (bit k-1 = stage k)
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Scoreboard entry per stage k: {v, rd, wb, ld}.
- Each cycle: entry[k+1] <= entry[k]; entry[DEPTH] is retired.
- entry[1] <= {of_valid, of_rd, of_wb, of_ld} when neither stall nor flush; otherwise a bubble (v=0).
- Match for source s at stage k: entry[k].v & entry[k].wb & entry[k].rd == s & use bit set. No hardwired-zero register; all addresses forward.
- Nearest match wins: the smallest k matching determines the hazard.
- If the nearest match is a load and k < LD_STAGE: load-use hazard, and stall=1 (when of_valid).
- Otherwise, when a match exists, fwd_sel = k.
- No match: fwd_sel = 0.
- An unused source always gives fwd_sel = 0 and never stalls.
- fwd_sel is only meaningful when stall=0. It is driven 0 while stall=1.
- flush = isBranchtaken & entry[1].v.
- Flush overrides stall: stall forced 0 when flush=1, because the OF instruction is being killed. fwd_sel is forced 0 as well.
- stall_cnt increments on every cycle stall=1; flush_cnt increments on every cycle flush=1. Both hold at 2^CNT_W-1.
- Stage DEPTH (RW) writes the register file at the end of the cycle, so a match at stage DEPTH is forwarded. No write-through is assumed from the register file.

## Timing
- stall, flush, fwd_sel* are combinational from registered scoreboard plus current OF inputs and isBranchtaken. Valid in the same cycle.
- Scoreboard and counters are registered; latency of one cycle per stage.
- Load-use stall length = LD_STAGE - k cycles for a nearest load at stage k. With defaults, an immediately dependent load stalls exactly 1 cycle, then forwards from stage 2.
- A taken branch in EX flushes for exactly one cycle. The next cycle, entry[1] holds a bubble, so flush cannot re-assert.
- Reset: while rst=1, all entry v cleared, counters cleared, and stall, flush, fwd_sel*, stage_valid all driven 0 regardless of inputs.
- First cycle after reset: no hazards, fwd_sel=0.
- Reset asserted mid-stall or mid-flush takes effect at the next edge. In-flight entries are dropped with no residual stall.
- of_valid=0: no stall, and a bubble enters EX.

## Test plan
- Reset: hold rst 3 cycles with of_valid=1 and isBranchtaken=1 → stall=0, flush=0, fwd_sel1=fwd_sel2=0, stage_valid=0, stall_cnt=flush_cnt=0.
- ALU chain, defaults: add r1 then add r2,r1,r1 issued next cycle → fwd_sel1=fwd_sel2=1, stall=0. The cycle after, a third instruction reading r1 → fwd_sel1=2.
- Load-use: ld r3 then add r4,r3,r5 → stall=1 for 1 cycle, stall_cnt=1, bubble at stage 1. Next cycle stall=0 and fwd_sel1=2.
- Nearest wins: writes to r6 at stages 3 and 1 → fwd_sel1=1. Only the stage 3 writer present → fwd_sel1=3. of_use_rs1=0 → 0.
- Branch: taken branch in EX while OF holds a load-use hazard → flush=1, stall=0, flush_cnt=1. Next cycle stage_valid[0]=0 and flush=0.
- Counter saturation with CNT_W=2: 5 stall cycles → stall_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage scoreboard from EX to RW driving operand
// forwarding selects, load-use stalls, branch flushes and saturating event counters.
module hazard_ctrl #(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 4,
  parameter int LD_STAGE = 2,
  parameter int CNT_W    = 16,
  parameter int FS_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              of_valid,
  input  logic [REG_AW-1:0] of_rs1,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_use_rs1,
  input  logic              of_use_rs2,
  input  logic [REG_AW-1:0] of_rd,
  input  logic              of_wb,
  input  logic              of_ld,
  input  logic              isBranchtaken,
  output logic              stall,
  output logic              flush,
  output logic [FS_W-1:0]   fwd_sel1,
  output logic [FS_W-1:0]   fwd_sel2,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [DEPTH:1]    v_q, v_d;
  logic [DEPTH:1]    wb_q, ld_q;
  logic [REG_AW-1:0] rd_q [1:DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [FS_W-1:0]   sel1, sel2;
  logic              ld1, ld2, haz1, haz2;
  logic              stall_w, flush_w;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Scan from the oldest stage down so the nearest (youngest) writer is kept last.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    ld1  = 1'b0;
    ld2  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v_q[k] && wb_q[k] && of_use_rs1 && (rd_q[k] == of_rs1)) begin
        sel1 = FS_W'(k);
        ld1  = ld_q[k];
      end
      if (v_q[k] && wb_q[k] && of_use_rs2 && (rd_q[k] == of_rs2)) begin
        sel2 = FS_W'(k);
        ld2  = ld_q[k];
      end
    end
  end

  assign haz1    = ld1 && (int'(sel1) < LD_STAGE);
  assign haz2    = ld2 && (int'(sel2) < LD_STAGE);
  assign flush_w = ~rst & isBranchtaken & v_q[1];
  assign stall_w = ~rst & ~flush_w & of_valid & (haz1 | haz2);

  assign stall       = stall_w;
  assign flush       = flush_w;
  assign fwd_sel1    = (rst | flush_w | stall_w | haz1) ? '0 : sel1;
  assign fwd_sel2    = (rst | flush_w | stall_w | haz2) ? '0 : sel2;
  assign stage_valid = rst ? '0 : v_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  always_comb begin
    v_d         = {v_q[DEPTH-1:1], of_valid & ~stall_w & ~flush_w};
    stall_cnt_d = stall_w ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush_w ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Entry payload needs no reset: it is ignored whenever its valid bit is clear.
  always_ff @(posedge clk) begin
    rd_q[1] <= of_rd;
    wb_q[1] <= of_wb;
    ld_q[1] <= of_ld;
    for (int k = 2; k <= DEPTH; k++) begin
      rd_q[k] <= rd_q[k-1];
      wb_q[k] <= wb_q[k-1];
      ld_q[k] <= ld_q[k-1];
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// list-of-in-flight-instructions reference model.
module tb_hazard_ctrl;
  localparam int DEPTH    = 3;
  localparam int LD_STAGE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       of_valid = 1'b0;
  logic [3:0] of_rs1 = '0, of_rs2 = '0, of_rd = '0;
  logic       of_use_rs1 = 1'b0, of_use_rs2 = 1'b0;
  logic       of_wb = 1'b0, of_ld = 1'b0, isBranchtaken = 1'b0;
  logic       stall, flush, stall_s, flush_s;
  logic [1:0] fwd_sel1, fwd_sel2, fwd_sel1_s, fwd_sel2_s;
  logic [DEPTH-1:0] stage_valid, stage_valid_s;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2), .of_rd(of_rd), .of_wb(of_wb),
    .of_ld(of_ld), .isBranchtaken(isBranchtaken), .stall(stall), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stage_valid(stage_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2), .of_rd(of_rd), .of_wb(of_wb),
    .of_ld(of_ld), .isBranchtaken(isBranchtaken), .stall(stall_s), .flush(flush_s),
    .fwd_sel1(fwd_sel1_s), .fwd_sel2(fwd_sel2_s), .stage_valid(stage_valid_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  typedef struct { bit v; bit [3:0] rd; bit wb; bit ld; } ent_t;
  ent_t pipe [1:DEPTH];
  int   m_sc = 0, m_fc = 0, m_sc_s = 0, m_fc_s = 0;
  bit   e_stall, e_flush;
  bit [1:0] e_f1, e_f2;
  bit [DEPTH-1:0] e_sv;
  int   checks = 0, failures = 0;

  function automatic void model_eval();
    int k1, k2;
    bit h1, h2;
    k1 = 0; k2 = 0; h1 = 0; h2 = 0;
    e_stall = 0; e_flush = 0; e_f1 = 0; e_f2 = 0; e_sv = '0;
    if (rst) return;
    e_flush = isBranchtaken && pipe[1].v;
    for (int k = 1; k <= DEPTH; k++) begin
      e_sv[k-1] = pipe[k].v;
      if (k1 == 0 && pipe[k].v && pipe[k].wb && of_use_rs1 && pipe[k].rd == of_rs1) k1 = k;
      if (k2 == 0 && pipe[k].v && pipe[k].wb && of_use_rs2 && pipe[k].rd == of_rs2) k2 = k;
    end
    if (k1 != 0) h1 = pipe[k1].ld && (k1 < LD_STAGE);
    if (k2 != 0) h2 = pipe[k2].ld && (k2 < LD_STAGE);
    e_stall = of_valid && (h1 || h2) && !e_flush;
    e_f1 = (e_stall || e_flush || h1) ? 2'd0 : 2'(k1);
    e_f2 = (e_stall || e_flush || h2) ? 2'd0 : 2'(k2);
  endfunction

  task automatic tick();
    model_eval();
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) pipe[k].v = 0;
      m_sc = 0; m_fc = 0; m_sc_s = 0; m_fc_s = 0;
    end else begin
      if (e_stall) begin
        if (m_sc < 65535) m_sc++;
        if (m_sc_s < 3) m_sc_s++;
      end
      if (e_flush) begin
        if (m_fc < 65535) m_fc++;
        if (m_fc_s < 3) m_fc_s++;
      end
      for (int k = DEPTH; k >= 2; k--) pipe[k] = pipe[k-1];
      pipe[1] = '{of_valid && !e_stall && !e_flush, of_rd, of_wb, of_ld};
    end
    @(posedge clk);
    #1;
    model_eval();
  endtask

  task automatic drive(input bit v, input bit [3:0] rs1, input bit u1, input bit [3:0] rs2,
                       input bit u2, input bit [3:0] rd, input bit wb, input bit ld, input bit br);
    of_valid = v; of_rs1 = rs1; of_use_rs1 = u1; of_rs2 = rs2; of_use_rs2 = u2;
    of_rd = rd; of_wb = wb; of_ld = ld; isBranchtaken = br;
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 1, 2, 1, 3, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall cyc%0d got=%0d exp=0", c, stall); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush cyc%0d got=%0d exp=0", c, flush); end
      checks++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin failures++; $display("FAIL rst_fwd cyc%0d got=%0d/%0d exp=0/0", c, fwd_sel1, fwd_sel2); end
      checks++; if (stage_valid !== '0) begin failures++; $display("FAIL rst_sv cyc%0d got=%b exp=000", c, stage_valid); end
      tick();
    end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0 || fwd_sel1 !== 2'd0) begin failures++; $display("FAIL post_rst got=%0d/%0d exp=0/0", stall, fwd_sel1); end
  endtask

  task automatic test_alu_chain();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    checks++; if (fwd_sel1 !== 2'd0 || stall !== 1'b0) begin failures++; $display("FAIL alu_first got=%0d/%0d exp=0/0", fwd_sel1, stall); end
    tick();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    checks++; if (fwd_sel1 !== 2'd1 || fwd_sel2 !== 2'd1) begin failures++; $display("FAIL alu_fwd1 got=%0d/%0d exp=1/1", fwd_sel1, fwd_sel2); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_nostall got=%0d exp=0", stall); end
    tick();
    drive(1, 1, 1, 0, 0, 7, 1, 0, 0);
    checks++; if (fwd_sel1 !== 2'd2 || fwd_sel2 !== 2'd0) begin failures++; $display("FAIL alu_fwd2 got=%0d/%0d exp=2/0", fwd_sel1, fwd_sel2); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
    tick();
    drive(1, 3, 1, 5, 1, 4, 1, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin failures++; $display("FAIL lu_fwd_held got=%0d exp=0", fwd_sel1); end
    tick();
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (stage_valid !== 3'b010) begin failures++; $display("FAIL lu_bubble got=%b exp=010", stage_valid); end
    checks++; if (stall !== 1'b0 || fwd_sel1 !== 2'd2 || fwd_sel2 !== 2'd0) begin failures++; $display("FAIL lu_release got=%0d/%0d/%0d exp=0/2/0", stall, fwd_sel1, fwd_sel2); end
    tick();
  endtask

  task automatic test_nearest();
    do_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); tick();
    drive(1, 6, 1, 0, 0, 10, 1, 0, 0);
    checks++; if (fwd_sel1 !== 2'd1) begin failures++; $display("FAIL near_s1 got=%0d exp=1", fwd_sel1); end
    drive(1, 6, 0, 0, 0, 10, 1, 0, 0);
    checks++; if (fwd_sel1 !== 2'd0) begin failures++; $display("FAIL near_unused got=%0d exp=0", fwd_sel1); end
    do_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    tick();
    drive(1, 6, 1, 6, 1, 10, 1, 0, 0);
    checks++; if (fwd_sel1 !== 2'd3 || fwd_sel2 !== 2'd3) begin failures++; $display("FAIL near_s3 got=%0d/%0d exp=3/3", fwd_sel1, fwd_sel2); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();
    drive(1, 3, 1, 5, 1, 4, 1, 0, 1);
    checks++; if (flush !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL br_flush got=%0d/%0d exp=1/0", flush, stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin failures++; $display("FAIL br_fwd got=%0d exp=0", fwd_sel1); end
    tick();
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin failures++; $display("FAIL br_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
    checks++; if (stage_valid[0] !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL br_once got=%0d/%0d exp=0/0", stage_valid[0], flush); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d exp=1", stall); end
    rst = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mid_rst got=%0d exp=0", stall); end
    tick();
    rst = 1'b0; #1; model_eval();
    checks++; if (stall !== 1'b0 || stage_valid !== 3'b000) begin failures++; $display("FAIL mid_after got=%0d/%b exp=0/000", stall, stage_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();
      drive(1, 3, 1, 5, 1, 4, 1, 0, 0); tick();
      tick();
    end
    checks++; if (stall_cnt_s !== 2'd3) begin failures++; $display("FAIL sat_small got=%0d exp=3", stall_cnt_s); end
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      checks++; if (stall !== e_stall) begin failures++; $display("FAIL rnd_stall c%0d got=%0d exp=%0d", c, stall, e_stall); end
      checks++; if (flush !== e_flush) begin failures++; $display("FAIL rnd_flush c%0d got=%0d exp=%0d", c, flush, e_flush); end
      checks++; if (fwd_sel1 !== e_f1 || fwd_sel2 !== e_f2) begin failures++; $display("FAIL rnd_fwd c%0d got=%0d/%0d exp=%0d/%0d", c, fwd_sel1, fwd_sel2, e_f1, e_f2); end
      checks++; if (stage_valid !== e_sv) begin failures++; $display("FAIL rnd_sv c%0d got=%b exp=%b", c, stage_valid, e_sv); end
      checks++; if (stall_cnt !== 16'(m_sc) || flush_cnt !== 16'(m_fc)) begin failures++; $display("FAIL rnd_cnt c%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, m_sc, m_fc); end
      checks++; if (stall_cnt_s !== 2'(m_sc_s) || flush_cnt_s !== 2'(m_fc_s)) begin failures++; $display("FAIL rnd_cnt_s c%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt_s, flush_cnt_s, m_sc_s, m_fc_s); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_nearest();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
